// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronizes and filters the raw lines, validates 11-bit frames and
// turns the W/A/D make/break stream into held-key levels for the movement controller.
module ps2_key_decoder #(
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_w,
    output logic       key_a,
    output logic       key_d,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err
);

    localparam int unsigned FiltW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned TmoW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [FiltW-1:0] FiltLast = FiltW'(FILTER_LEN - 1);
    localparam logic [TmoW-1:0]  TmoLast  = TmoW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] CodeW     = 8'h1D;
    localparam logic [7:0] CodeA     = 8'h1C;
    localparam logic [7:0] CodeD     = 8'h23;
    localparam logic [7:0] CodeExt   = 8'hE0;
    localparam logic [7:0] CodeBreak = 8'hF0;

    typedef enum logic [1:0] {RxIdle, RxRecv, RxCheck} rx_state_e;
    typedef enum logic [1:0] {DecNormal, DecBreak, DecExt, DecExtBreak} dec_state_e;

    logic             clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
    logic             filt_clk_q;
    logic [FiltW-1:0] filt_cnt_q;
    logic             fall_q;
    rx_state_e        rx_state_q;
    logic [10:0]      shift_q;
    logic [3:0]       bit_cnt_q;
    logic [TmoW-1:0]  tmo_cnt_q;
    dec_state_e       dec_state_q;
    logic             frame_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            data_s1_q <= 1'b1;
            data_s2_q <= 1'b1;
        end else begin
            clk_s1_q  <= ps2_clk;
            clk_s2_q  <= clk_s1_q;
            data_s1_q <= ps2_data;
            data_s2_q <= data_s1_q;
        end
    end

    // Filtered clock follows only after FILTER_LEN consecutive samples at the new level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_clk_q <= 1'b1;
            filt_cnt_q <= '0;
            fall_q     <= 1'b0;
        end else begin
            fall_q <= 1'b0;
            if (clk_s2_q == filt_clk_q) begin
                filt_cnt_q <= '0;
            end else if (filt_cnt_q == FiltLast) begin
                filt_clk_q <= clk_s2_q;
                filt_cnt_q <= '0;
                fall_q     <= filt_clk_q;
            end else begin
                filt_cnt_q <= filt_cnt_q + FiltW'(1);
            end
        end
    end

    // shift_q[0]=start, [8:1]=data, [9]=parity, [10]=stop once all 11 bits are in.
    assign frame_ok = ~shift_q[0] & shift_q[10] & (^shift_q[9:1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q <= RxIdle;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
            scan_code  <= 8'h00;
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
            unique case (rx_state_q)
                RxIdle: begin
                    tmo_cnt_q <= '0;
                    if (fall_q && !data_s2_q) begin
                        shift_q    <= {data_s2_q, 10'b0};
                        bit_cnt_q  <= 4'd1;
                        rx_state_q <= RxRecv;
                    end
                end
                RxRecv: begin
                    if (fall_q) begin
                        shift_q   <= {data_s2_q, shift_q[10:1]};
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        tmo_cnt_q <= '0;
                        if (bit_cnt_q == 4'd10) begin
                            rx_state_q <= RxCheck;
                        end
                    end else if (tmo_cnt_q == TmoLast) begin
                        frame_err  <= 1'b1;
                        rx_state_q <= RxIdle;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
                    end
                end
                RxCheck: begin
                    if (frame_ok) begin
                        scan_code  <= shift_q[8:1];
                        scan_valid <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                    rx_state_q <= RxIdle;
                end
                default: rx_state_q <= RxIdle;
            endcase
        end
    end

    // A rejected frame resynchronizes the prefix tracking but never touches held keys.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_state_q <= DecNormal;
            key_w       <= 1'b0;
            key_a       <= 1'b0;
            key_d       <= 1'b0;
        end else if (frame_err) begin
            dec_state_q <= DecNormal;
        end else if (scan_valid) begin
            unique case (dec_state_q)
                DecNormal: begin
                    if (scan_code == CodeExt) begin
                        dec_state_q <= DecExt;
                    end else if (scan_code == CodeBreak) begin
                        dec_state_q <= DecBreak;
                    end else begin
                        if (scan_code == CodeW) key_w <= 1'b1;
                        if (scan_code == CodeA) key_a <= 1'b1;
                        if (scan_code == CodeD) key_d <= 1'b1;
                    end
                end
                DecBreak: begin
                    if (scan_code == CodeW) key_w <= 1'b0;
                    if (scan_code == CodeA) key_a <= 1'b0;
                    if (scan_code == CodeD) key_d <= 1'b0;
                    dec_state_q <= DecNormal;
                end
                DecExt: begin
                    dec_state_q <= (scan_code == CodeBreak) ? DecExtBreak : DecNormal;
                end
                DecExtBreak: begin
                    dec_state_q <= DecNormal;
                end
                default: dec_state_q <= DecNormal;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder; expected scan events queue up as frames are driven and are
// matched against every scan_valid / frame_err strobe. PS/2 clock is scaled down to keep runs short.
module tb_ps2_key_decoder;

    localparam int unsigned FilterLen     = 4;
    localparam int unsigned TimeoutCycles = 200;
    localparam int          Half          = 20;

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic       key_w, key_a, key_d;
    logic [7:0] scan_code;
    logic       scan_valid, frame_err;

    typedef struct packed {
        logic       is_err;
        logic [7:0] code;
    } exp_t;

    exp_t       exp_q[$];
    int         errors = 0;
    int         checks = 0;
    logic       prev_sv = 1'b0;
    logic [2:0] keys_at_sv = 3'b000;
    logic [2:0] keys_after_sv = 3'b000;

    always #5 clk = ~clk;

    ps2_key_decoder #(
        .FILTER_LEN     (FilterLen),
        .TIMEOUT_CYCLES (TimeoutCycles)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .key_w      (key_w),
        .key_a      (key_a),
        .key_d      (key_d),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .frame_err  (frame_err)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic check_keys(input string tag, input logic [2:0] want);
        check(tag, {13'b0, key_w, key_a, key_d}, {13'b0, want});
    endtask

    // One clock, sampled on the falling edge; every output strobe is scored here.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (scan_valid || frame_err) begin
            check("strobes exclusive", 16'(scan_valid & frame_err), 16'd0);
            if (exp_q.size() == 0) begin
                check("unexpected strobe", {14'b0, scan_valid, frame_err}, 16'd0);
            end else begin
                e = exp_q.pop_front();
                check("event kind (frame_err)", 16'(frame_err), 16'(e.is_err));
                if (!e.is_err) check("scan_code", 16'(scan_code), 16'(e.code));
            end
        end
        if (prev_sv) keys_after_sv = {key_w, key_a, key_d};
        if (scan_valid) keys_at_sv = {key_w, key_a, key_d};
        prev_sv = scan_valid;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_bits(input logic [7:0] code, input logic bad_par, input int nbits);
        logic [10:0] frame;
        frame = {1'b1, (~^code) ^ bad_par, code, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = frame[i];
            ticks(Half / 2);
            ps2_clk = 1'b0;
            ticks(Half);
            ps2_clk = 1'b1;
            ticks(Half / 2);
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] code, input logic bad_par);
        exp_q.push_back(exp_t'({bad_par, code}));
        send_bits(code, bad_par, 11);
        ticks(20);
    endtask

    task automatic check_drained(input string tag);
        check(tag, 16'(exp_q.size()), 16'd0);
    endtask

    initial begin
        #1 rst = 1'b1;
        ticks(3);
        check_keys("reset keys", 3'b000);
        check("reset scan_code", 16'(scan_code), 16'h00);
        check("reset strobes", {14'b0, scan_valid, frame_err}, 16'd0);
        rst = 1'b0;
        ticks(10);

        // Press W: key follows scan_valid by exactly one cycle.
        send_byte(8'h1D, 1'b0);
        check_drained("press W drained");
        check("W keys at scan_valid", 16'(keys_at_sv), 16'(3'b000));
        check("W keys after scan_valid", 16'(keys_after_sv), 16'(3'b100));
        check_keys("press W", 3'b100);

        // Press and release A while W stays held.
        send_byte(8'h1C, 1'b0);
        check_keys("press A", 3'b110);
        send_byte(8'hF0, 1'b0);
        check_keys("break prefix", 3'b110);
        send_byte(8'h1C, 1'b0);
        check_drained("press/release A drained");
        check("A release at scan_valid", 16'(keys_at_sv), 16'(3'b110));
        check("A release after", 16'(keys_after_sv), 16'(3'b100));
        check_keys("release A", 3'b100);

        // Parity error is rejected; scan_code keeps the last good byte.
        send_byte(8'h23, 1'b1);
        check_drained("parity err drained");
        check_keys("after parity err", 3'b100);
        check("scan_code kept", 16'(scan_code), 16'h1C);
        send_byte(8'h23, 1'b0);
        check_keys("good D", 3'b101);

        // Timeout after 5 bits, then a typematic W repeat.
        exp_q.push_back(exp_t'({1'b1, 8'h00}));
        send_bits(8'h1D, 1'b0, 5);
        ticks(TimeoutCycles + 40);
        check_drained("timeout drained");
        check_keys("after timeout", 3'b101);
        send_byte(8'h1D, 1'b0);
        check_keys("typematic W", 3'b101);

        // Extended break of 1D leaves W held; a following make proves NORMAL state.
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1D, 1'b0);
        check_keys("ext break W", 3'b101);
        send_byte(8'h1C, 1'b0);
        check_keys("A after ext break", 3'b111);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1D, 1'b0);
        check_keys("release W", 3'b011);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h23, 1'b0);
        check_keys("release D", 3'b010);
        check_drained("ext sequence drained");

        // Short glitch on the PS/2 clock while idle.
        ps2_clk = 1'b0;
        ticks(2);
        ps2_clk = 1'b1;
        ticks(40);
        check_drained("glitch no activity");
        check_keys("glitch keys", 3'b010);

        // Asynchronous reset mid-frame with A held.
        send_bits(8'h1D, 1'b0, 4);
        #2 rst = 1'b1;
        #1;
        check_keys("async reset keys", 3'b000);
        check("async reset scan_code", 16'(scan_code), 16'h00);
        check("async reset strobes", {14'b0, scan_valid, frame_err}, 16'd0);
        ticks(3);
        rst = 1'b0;
        ticks(10);
        check_drained("reset no strobes");
        send_byte(8'h1C, 1'b0);
        check_drained("post-reset drained");
        check_keys("post-reset A", 3'b010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Upstream input stage for the character movement controller. Receives raw PS/2 keyboard clock and data lines and validates each 11-bit frame. Turns the make/break scan-code stream into three held-key levels, `key_w`, `key_a` and `key_d`, which connect directly to the movement FSM's key inputs. Also exposes the last valid byte and status strobes for debug.

## Interface
Parameters:
- `FILTER_LEN`, default 4: consecutive equal synchronized samples required before the filtered PS/2 clock changes level.
- `TIMEOUT_CYCLES`, default 65000: `clk` cycles allowed between PS/2 clock falling edges inside a frame.

Ports:
- `clk`  input  1  system clock.
- `rst`  input  1  reset, asynchronous, active-high. One clock; reset is asynchronous and active-high.
- `ps2_clk`  input  1  raw PS/2 clock, asynchronous to `clk`.
- `ps2_data`  input  1  raw PS/2 data, asynchronous to `clk`.
- `key_w`  output  1  W held (scan code 0x1D).
- `key_a`  output  1  A held (0x1C).
- `key_d`  output  1  D held (0x23).
- `scan_code`  output  8  last byte received with a valid frame.
- `scan_valid`  output  1  one-cycle strobe: `scan_code` was just updated.
- `frame_err`  output  1  one-cycle strobe: frame rejected (bad start, stop or parity) or timed out.

## Operation
- **Synchronization:** 2-FF synchronizer on `ps2_clk` and on `ps2_data`; both synchronizer stages reset to 1.
- **Clock filter:** the filtered clock (reset value 1) takes the synchronized level only after `FILTER_LEN` consecutive identical samples. A falling edge means the filtered clock goes 1→0, detected as a one-cycle `fall` pulse.
- **RX FSM** (states IDLE, RECV, CHECK; reset to IDLE):
  - IDLE: on `fall` with synced data = 0, capture the start bit, set `bit_cnt` = 1, go to RECV. On `fall` with data = 1, ignore.
  - RECV: on each `fall`, shift the data bit into an 11-bit register (LSB first) and increment `bit_cnt`. When the bit with `bit_cnt` = 10 (stop) is captured, go to CHECK.
  - RECV timeout: the timeout counter clears on every `fall`. When it reaches `TIMEOUT_CYCLES`-1, drop the partial frame, pulse `frame_err`, go to IDLE.
  - CHECK (one cycle): the frame is valid iff start = 0, stop = 1, and the 9 bits data+parity have odd parity.
    - Valid: load `scan_code`, pulse `scan_valid`.
    - Invalid: pulse `frame_err`.
    - Always go to IDLE.
- **Decode FSM** (states NORMAL, BREAK, EXT, EXT_BREAK; reset to NORMAL). It acts only on `scan_valid`.
  - NORMAL:
    - 0xE0 → EXT.
    - 0xF0 → BREAK.
    - 0x1D / 0x1C / 0x23 → set `key_w` / `key_a` / `key_d` respectively.
    - Any other byte → ignored.
  - BREAK: 0x1D / 0x1C / 0x23 → clear the matching key. Any byte → NORMAL.
  - EXT: 0xF0 → EXT_BREAK. Any other byte → NORMAL, no key change (extended keys are unmapped).
  - EXT_BREAK: any byte → NORMAL, no key change.
  - On `frame_err`: decode FSM returns to NORMAL; key levels are retained.
- Typematic repeats (repeated make codes) leave an already-set key at 1.
- Several keys may be held simultaneously; each key is tracked independently.

## Timing
- Reset values: `key_w` = `key_a` = `key_d` = 0, `scan_code` = 0x00, `scan_valid` = 0, `frame_err` = 0. Reset mid-frame discards all partial state immediately.
- `fall` asserts 2 + `FILTER_LEN` cycles after a clean raw falling edge (±1 cycle for synchronizer phase).
- The stop bit is captured on the `fall` cycle. CHECK is the next cycle; `scan_valid`/`scan_code` and `frame_err` are registered and visible the cycle after CHECK.
- `key_*` change exactly 1 cycle after the `scan_valid` cycle.
- `scan_valid` and `frame_err` are never both high; each is high for exactly one cycle per event.
- All outputs are registered; no combinational path from `ps2_*` to outputs.
- Raw glitches shorter than `FILTER_LEN` cycles produce no `fall`.

## Test plan
- **Press W:** send a valid 0x1D frame (parity 1) at a 10 kHz PS/2 clock → one `scan_valid` with `scan_code` = 0x1D; `key_w` = 1 one cycle later; `key_a`, `key_d` stay 0.
- **Press and release A:** send 0x1C, 0xF0, 0x1C → `key_a` rises after the first byte and falls after the third; three `scan_valid` pulses, no `frame_err`.
- **Parity error:** send 0x23 with wrong parity → `frame_err` pulse, no `scan_valid`, `key_d` stays 0; a following good 0x23 sets `key_d`.
- **Timeout:** stop the PS/2 clock after 5 bits for > `TIMEOUT_CYCLES` → one `frame_err`; a subsequent full 0x1D frame decodes correctly.
- **Extended break:** with W held, send E0, F0, 1D → `key_w` stays 1 and the decode FSM ends in NORMAL. Then F0, 1D → `key_w` = 0.
- **Glitch and reset:** inject a 2-cycle low glitch on `ps2_clk` while idle → no RX activity. Assert `rst` mid-frame with A held → all outputs 0 immediately; the next clean frame decodes normally.
